seq_shift_add_multiplier: RTL and testbench

- Iterative radix-2 shift-add multiplier. Generalises the combinational unsigned array multiplier into a parametrised, multi-cycle block.
- Adds a per-operation signed/unsigned mode, valid/ready handshakes on input and output, and synchronous reset.
- Trades throughput for area: one adder of width 2*WIDTH, reused over WIDTH cycles.
- Used wherever datapath blocks need an occasional multiply without a full array.

---
 rtl/seq_shift_add_multiplier.sv | 166 ++++++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Iterative radix-2 shift-add multiplier. One 2*WIDTH-bit adder is reused
// over WIDTH cycles. Each operation can be signed (two's complement) or
// unsigned. Operands enter and the product leaves through valid/ready
// handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand request valid
//   in_ready   operands can be accepted (IDLE only)
//   ina        multiplicand, WIDTH bits
//   inb        multiplier, WIDTH bits
//   is_signed  1 = two's-complement operands and product, 0 = unsigned
//   out_valid  product available (DONE only)
//   out_ready  consumer accepts the product
//   out        registered product, 2*WIDTH bits
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_out;

  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [2*WIDTH-1:0]   w_result;

  // Magnitudes of the operands. For the most negative value the negation
  // wraps back to 2^(WIDTH-1), which is exactly the magnitude as unsigned.
  always_comb begin
    w_abs_a = ina;
    w_abs_b = inb;
    if (is_signed && ina[WIDTH-1]) begin
      w_abs_a = ~ina + 1'b1;
    end
    if (is_signed && inb[WIDTH-1]) begin
      w_abs_b = ~inb + 1'b1;
    end
  end

  // One partial product per cycle: multiplicand shifted by the iteration
  // index, added only when the current multiplier bit is set.
  always_comb begin
    w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    w_addend  = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    w_acc_nxt = r_acc;
    if (r_mplier[0]) begin
      w_acc_nxt = r_acc + w_addend;
    end
    w_result = w_acc_nxt;
    if (r_neg) begin
      w_result = ~w_acc_nxt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out = r_out;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_out    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_neg    <= is_signed & (ina[WIDTH-1] ^ inb[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_out <= w_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_multiplier
//
// Directed bench for seq_shift_add_multiplier at WIDTH=8, followed by a
// random sweep checked against a behavioural product.
// ---------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  ina;
  logic [7:0]  inb;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  seq_shift_add_multiplier #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ina       (ina),
    .inb       (inb),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
    int pa;
    int pb;
    if (s) begin
      pa = int'($signed(a));
      pb = int'($signed(b));
    end else begin
      pa = int'(a);
      pb = int'(b);
    end
    return 16'(pa * pb);
  endfunction

  // One complete transaction: accept, count latency, check the product,
  // hold the result for 'hold' cycles, then release it.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] exp, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    ina       = a;
    inb       = b;
    is_signed = s;
    in_valid  = 1'b1;
    tick();
    acc_cyc   = cyc;
    in_valid  = 1'b0;
    // scramble inputs while busy; the block must not look at them
    ina       = 8'($urandom);
    inb       = 8'($urandom);
    is_signed = 1'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 16'(n), 16'd8);
    check({tag, " product"}, out, exp);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " release"}, 16'({out_valid, in_ready}), 16'b01);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    int         prev;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ina       = '0;
    inb       = '0;
    is_signed = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset out", out, 16'h0000);
    check("reset out_valid", 16'(out_valid), 16'd0);
    check("reset in_ready", 16'(in_ready), 16'd1);
    rst = 1'b0;

    // Directed products
    do_op("u ff*ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    do_op("s 80*80", 8'h80, 8'h80, 1'b1, 16'h4000, 0);
    do_op("s fd*05", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 1);
    do_op("u fd*05", 8'hFD, 8'h05, 1'b0, 16'h04F1, 0);
    do_op("u 00*a5", 8'h00, 8'hA5, 1'b0, 16'h0000, 0);
    do_op("s 7f*80", 8'h7F, 8'h80, 1'b1, 16'hC080, 0);
    do_op("s ff*ff", 8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
    do_op("u 80*02", 8'h80, 8'h02, 1'b0, 16'h0100, 2);
    do_op("s 80*00", 8'h80, 8'h00, 1'b1, 16'h0000, 0);

    // Backpressure: 18*52 = 936, held for 20 cycles while in_valid pulses
    ina       = 8'h12;
    inb       = 8'h34;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    repeat (8) tick();
    check("bp first valid", 16'(out_valid), 16'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      ina       = 8'h55;
      inb       = 8'h66;
      tick();
      check("bp out_valid", 16'(out_valid), 16'd1);
      check("bp out", out, 16'h03A8);
      check("bp in_ready", 16'(in_ready), 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp release valid", 16'(out_valid), 16'd0);
    check("bp release ready", 16'(in_ready), 16'd1);

    // Reset during iteration 4 of 0x7F*0x7F
    ina       = 8'h7F;
    inb       = 8'h7F;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst out", out, 16'h0000);
    check("midrst out_valid", 16'(out_valid), 16'd0);
    check("midrst in_ready", 16'(in_ready), 16'd1);
    do_op("after rst 03*04", 8'h03, 8'h04, 1'b0, 16'h000C, 0);

    // Random sweep with random output stalls
    prev = 0;
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      do_op("rand", a, b, s, ref_mul(a, b, s), int'($urandom_range(0, 3)));
      if (k > 0) begin
        check("rand spacing", 16'(acc_cyc - prev >= 10), 16'd1);
      end
      prev = acc_cyc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
